// File: rtl/pokey_audio_pkg.sv
// pokey_audio_pkg: shared widths and saturation helper for the POKEY audio back end
package pokey_audio_pkg;
  localparam int AUD_IN_W = 6;
  localparam int SAMPLE_W = 10;
  localparam int SAMPLE_MAX = 1023;
  function automatic logic [SAMPLE_W-1:0] sat10(input logic [11:0] v);
    return v > 12'(SAMPLE_MAX) ? SAMPLE_W'(SAMPLE_MAX) : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/pokey_sdm1.sv
// pokey_sdm1: first-order sigma-delta modulator, carry of the phase accumulator is the output bit
module pokey_sdm1
  import pokey_audio_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                bit_o
);
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0] nxt;
  assign nxt = {1'b0, acc} + {1'b0, sample_i};
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc <= '0;
      bit_o <= 1'b0;
    end else begin
      acc <= nxt[SAMPLE_W-1:0];
      bit_o <= nxt[SAMPLE_W];
    end
  end
endmodule

// File: rtl/pokey_audio_dac.sv
// pokey_audio_dac: mixes POKEY outputs, scales with saturation, resamples and drives a 1-bit DAC
module pokey_audio_dac
  import pokey_audio_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int SAMPLE_DIV = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [AUD_IN_W*NUM_CH-1:0] audin_i,
  input  logic [NUM_CH-1:0]          ch_mute_i,
  input  logic [1:0]                 gain_i,
  input  logic                       clip_clr_i,
  output logic [SAMPLE_W-1:0]        sample_o,
  output logic                       sample_stb_o,
  output logic                       clip_o,
  output logic                       dac_o
);
  localparam int DW = $clog2(SAMPLE_DIV);
  logic [7:0] mix, sum_r;
  logic [DW-1:0] div;
  logic [11:0] scaled;
  logic latch;
  always_comb begin
    mix = '0;
    for (int k = 0; k < NUM_CH; k++)
      mix = mix + (ch_mute_i[k] ? 8'd0 : 8'(audin_i[AUD_IN_W*k +: AUD_IN_W]));
  end
  assign latch = div == DW'(SAMPLE_DIV - 1);
  assign scaled = {4'b0, sum_r} << gain_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_r <= '0;
      div <= '0;
      sample_o <= '0;
      sample_stb_o <= 1'b0;
      clip_o <= 1'b0;
    end else begin
      sum_r <= mix;
      div <= latch ? '0 : div + DW'(1);
      sample_stb_o <= latch;
      if (latch) sample_o <= sat10(scaled);
      // a saturating latch beats a simultaneous clear
      if (latch && scaled > 12'(SAMPLE_MAX)) clip_o <= 1'b1;
      else if (clip_clr_i) clip_o <= 1'b0;
    end
  end
  pokey_sdm1 u_sdm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .sample_i(sample_o),
    .bit_o   (dac_o)
  );
endmodule
